xdisplay_ctrl: RTL and testbench

Scan controller for the 4-digit 7-segment display of the memory-game board. It holds one segment pattern per digit, written over the peripheral bus through the external address decoder's display select lines. It time-multiplexes the shared cathode lines across the four anodes, with a blanking interval per slot to suppress ghosting. It also provides per-digit blinking and a frame-complete pulse that software or the timer can use as a slow tick.

---
 rtl/xdisplay_ctrl.sv | 118 +++++++++++
 tb/tb_xdisplay_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/xdisplay_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with per-digit blanking,
// per-digit blink and a frame-complete tick.
module xdisplay_ctrl #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK     = 16,
  parameter int BLINK_DIV = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  wr_sel,
  input  logic [7:0]  wr_data,
  input  logic        cfg_we,
  output logic [11:0] seg,
  output logic        frame_tc
);

  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int FCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_DIV - 1);

  logic [7:0]        digit_reg [4];
  logic [3:0]        blink_mask;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        idx;
  logic [FCNT_W-1:0] fcnt;
  logic              blink_phase;

  logic slot_wrap;
  logic frame_end;
  logic in_blank;
  logic blink_hide;

  function automatic logic [3:0] anode_sel(input logic [1:0] i);
    return ~(4'b0001 << i);
  endfunction

  function automatic logic [11:0] seg_pattern(input logic       blank,
                                              input logic [1:0] i,
                                              input logic       hide,
                                              input logic [7:0] cath);
    if (blank)
      return 12'hFFF;
    return {anode_sel(i), hide ? 8'hFF : cath};
  endfunction

  // A zero-length blanking window would make the compare constant-false.
  generate
    if (BLANK == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK);
      assign in_blank = (cnt < BLANK_C);
    end
  endgenerate

  assign slot_wrap  = (cnt == CNT_LAST);
  assign frame_end  = slot_wrap && (idx == 2'd3);
  assign blink_hide = blink_mask[idx] && blink_phase;

  // Scan timing: slot counter, digit index, frame tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= 2'd0;
      frame_tc <= 1'b0;
    end else begin
      frame_tc <= frame_end;
      if (slot_wrap) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Blink control: a config write restarts blinking visible and wins over frame-end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_mask  <= 4'b0000;
      fcnt        <= '0;
      blink_phase <= 1'b0;
    end else if (cfg_we) begin
      blink_mask  <= wr_data[3:0];
      fcnt        <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (fcnt == FCNT_LAST) begin
        fcnt        <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        fcnt <= fcnt + FCNT_W'(1);
      end
    end
  end

  // Digit pattern registers, independently strobed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++)
        digit_reg[i] <= 8'hFF;
    end else begin
      for (int i = 0; i < 4; i++)
        if (wr_sel[i])
          digit_reg[i] <= wr_data;
    end
  end

  // Output stage: registered drive from pre-edge scan state
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      seg <= 12'hFFF;
    else
      seg <= seg_pattern(in_blank, idx, blink_hide, digit_reg[idx]);
  end

endmodule

// File: tb/tb_xdisplay_ctrl.sv
// Directed bench for xdisplay_ctrl with CLK_DIV=4, BLANK=1, BLINK_DIV=2;
// every edge is checked against hand-derived seg / frame_tc values.
module tb_xdisplay_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  wr_sel;
  logic [7:0]  wr_data;
  logic        cfg_we;
  logic [11:0] seg;
  logic        frame_tc;

  int n_vec;
  int n_fail;

  xdisplay_ctrl #(
    .CLK_DIV  (4),
    .BLANK    (1),
    .BLINK_DIV(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .cfg_we  (cfg_we),
    .seg     (seg),
    .frame_tc(frame_tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_now(input logic [11:0] es, input logic et, input string tag);
    n_vec++;
    assert (seg === es) else begin
      n_fail++;
      $error("FAIL %s seg=%h expected=%h", tag, seg, es);
    end
    n_vec++;
    assert (frame_tc === et) else begin
      n_fail++;
      $error("FAIL %s frame_tc=%b expected=%b", tag, frame_tc, et);
    end
  endtask

  task automatic run_edge(input logic [11:0] es, input logic et, input string tag);
    @(posedge clk);
    #2;
    check_now(es, et, tag);
  endtask

  // One digit slot: one blank edge, three show edges.
  task automatic slot(input int d, input logic [7:0] c, input logic last,
                      input logic cfg_last, input string tag);
    logic [3:0] an;
    an    = 4'hF;
    an[d] = 1'b0;
    run_edge(12'hFFF, 1'b0, tag);
    run_edge({an, c}, 1'b0, tag);
    run_edge({an, c}, 1'b0, tag);
    if (cfg_last) begin
      cfg_we  = 1'b1;
      wr_data = 8'h02;
    end
    run_edge({an, c}, last, tag);
    cfg_we = 1'b0;
  endtask

  task automatic frame(input logic [7:0] c0, input logic [7:0] c1,
                       input logic [7:0] c2, input logic [7:0] c3,
                       input logic cfg_last, input string tag);
    slot(0, c0, 1'b0, 1'b0, tag);
    slot(1, c1, 1'b0, 1'b0, tag);
    slot(2, c2, 1'b0, 1'b0, tag);
    slot(3, c3, 1'b1, cfg_last, tag);
  endtask

  initial begin
    n_vec   = 0;
    n_fail  = 0;
    rst     = 1'b1;
    wr_sel  = 4'b0000;
    wr_data = 8'h00;
    cfg_we  = 1'b0;

    // Reset and idle: edges 1..16
    repeat (3) @(posedge clk);
    #2;
    check_now(12'hFFF, 1'b0, "reset_hold");
    rst = 1'b0;
    frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, "idle");

    // Digit writes: all four with C0, then digit 2 with F9 (edges 17..32)
    wr_sel  = 4'b1111;
    wr_data = 8'hC0;
    run_edge(12'hFFF, 1'b0, "wr_e1");
    wr_sel  = 4'b0100;
    wr_data = 8'hF9;
    run_edge(12'hEC0, 1'b0, "wr_e2");
    wr_sel  = 4'b0000;
    run_edge(12'hEC0, 1'b0, "wr_e3");
    run_edge(12'hEC0, 1'b0, "wr_e4");
    slot(1, 8'hC0, 1'b0, 1'b0, "wr");
    slot(2, 8'hF9, 1'b0, 1'b0, "wr");
    slot(3, 8'hC0, 1'b1, 1'b0, "wr");

    // Blink: digit 1 = A4, mask = 0x02 (frame 1 = edges 33..48)
    wr_sel  = 4'b0010;
    wr_data = 8'hA4;
    run_edge(12'hFFF, 1'b0, "blk1_e1");
    wr_sel  = 4'b0000;
    cfg_we  = 1'b1;
    wr_data = 8'h02;
    run_edge(12'hEC0, 1'b0, "blk1_e2");
    cfg_we  = 1'b0;
    run_edge(12'hEC0, 1'b0, "blk1_e3");
    run_edge(12'hEC0, 1'b0, "blk1_e4");
    slot(1, 8'hA4, 1'b0, 1'b0, "blk1");
    slot(2, 8'hF9, 1'b0, 1'b0, "blk1");
    slot(3, 8'hC0, 1'b1, 1'b0, "blk1");
    frame(8'hC0, 8'hA4, 8'hF9, 8'hC0, 1'b0, "blk2");
    frame(8'hC0, 8'hFF, 8'hF9, 8'hC0, 1'b0, "blk3");
    frame(8'hC0, 8'hFF, 8'hF9, 8'hC0, 1'b0, "blk4");
    frame(8'hC0, 8'hA4, 8'hF9, 8'hC0, 1'b0, "blk5");

    // cfg_we on frame-ending edges: keeps phase visible and restarts fcnt
    frame(8'hC0, 8'hA4, 8'hF9, 8'hC0, 1'b1, "coll_a");
    frame(8'hC0, 8'hA4, 8'hF9, 8'hC0, 1'b1, "coll_b");
    frame(8'hC0, 8'hA4, 8'hF9, 8'hC0, 1'b0, "coll_c");
    frame(8'hC0, 8'hA4, 8'hF9, 8'hC0, 1'b0, "coll_d");
    frame(8'hC0, 8'hFF, 8'hF9, 8'hC0, 1'b0, "coll_e");

    // Mid-slot write of digit 0 at the frame's third edge (hidden phase frame)
    run_edge(12'hFFF, 1'b0, "mw_e1");
    run_edge(12'hEC0, 1'b0, "mw_e2");
    wr_sel  = 4'b0001;
    wr_data = 8'h80;
    run_edge(12'hEC0, 1'b0, "mw_e3");
    wr_sel  = 4'b0000;
    run_edge(12'hE80, 1'b0, "mw_e4");
    slot(1, 8'hFF, 1'b0, 1'b0, "mw");
    slot(2, 8'hF9, 1'b0, 1'b0, "mw");
    slot(3, 8'hC0, 1'b1, 1'b0, "mw");

    // Async reset between edges 7 and 8 of a visible frame
    slot(0, 8'h80, 1'b0, 1'b0, "ar_pre");
    run_edge(12'hFFF, 1'b0, "ar_e5");
    run_edge(12'hDA4, 1'b0, "ar_e6");
    run_edge(12'hDA4, 1'b0, "ar_e7");
    rst = 1'b1;
    #1;
    check_now(12'hFFF, 1'b0, "ar_async");
    run_edge(12'hFFF, 1'b0, "ar_hold");
    rst = 1'b0;
    frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, "ar_restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
